// File: rtl/fetch_decode_skid.sv
// fetch_decode_skid
// Bundle-granular two-entry skid buffer between the instruction buffer and the
// decode stage. A bundle holds up to three lanes plus one RAS checkpoint. The
// buffer holds bundles in two registers:
//   OUT  - the bundle presented to decode
//   SKID - one more bundle, taken while decode is stalled
// decode_ready_o comes from a flop, so it never combinationally depends on
// out_ready_i.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush_i               discard everything held and any same-cycle input
//   decode_valid_i/_ready_o  handshake with the instruction buffer (lane mask / all-equal ready)
//   *_i_0/1/2             per-lane payload in
//   ras_tos_checkpoint_i  per-bundle RAS checkpoint in
//   out_valid_o/out_ready_i  handshake with decode (lane mask / whole-bundle consume)
//   *_o_0/1/2, ras_tos_checkpoint_o  registered payload out
//
// Optional build macro FETCH_DECODE_SKID_PERF_EN adds saturating counters
// stall_cycles_o, bubble_cycles_o and bundles_o.
module fetch_decode_skid #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,

    input  logic [2:0]                    decode_valid_i,
    output logic [2:0]                    decode_ready_o,

    input  logic [DATA_WIDTH-1:0]         instruction_i_0,
    input  logic [DATA_WIDTH-1:0]         instruction_i_1,
    input  logic [DATA_WIDTH-1:0]         instruction_i_2,
    input  logic [DATA_WIDTH-1:0]         pc_i_0,
    input  logic [DATA_WIDTH-1:0]         pc_i_1,
    input  logic [DATA_WIDTH-1:0]         pc_i_2,
    input  logic [DATA_WIDTH-1:0]         imm_i_0,
    input  logic [DATA_WIDTH-1:0]         imm_i_1,
    input  logic [DATA_WIDTH-1:0]         imm_i_2,
    input  logic [DATA_WIDTH-1:0]         pc_at_prediction_i_0,
    input  logic [DATA_WIDTH-1:0]         pc_at_prediction_i_1,
    input  logic [DATA_WIDTH-1:0]         pc_at_prediction_i_2,
    input  logic                          branch_prediction_i_0,
    input  logic                          branch_prediction_i_1,
    input  logic                          branch_prediction_i_2,
    input  logic [$clog2(ENTRIES):0]      global_history_i_0,
    input  logic [$clog2(ENTRIES):0]      global_history_i_1,
    input  logic [$clog2(ENTRIES):0]      global_history_i_2,
    input  logic [2:0]                    ras_tos_checkpoint_i,

    output logic [2:0]                    out_valid_o,
    input  logic                          out_ready_i,

    output logic [DATA_WIDTH-1:0]         instruction_o_0,
    output logic [DATA_WIDTH-1:0]         instruction_o_1,
    output logic [DATA_WIDTH-1:0]         instruction_o_2,
    output logic [DATA_WIDTH-1:0]         pc_o_0,
    output logic [DATA_WIDTH-1:0]         pc_o_1,
    output logic [DATA_WIDTH-1:0]         pc_o_2,
    output logic [DATA_WIDTH-1:0]         imm_o_0,
    output logic [DATA_WIDTH-1:0]         imm_o_1,
    output logic [DATA_WIDTH-1:0]         imm_o_2,
    output logic [DATA_WIDTH-1:0]         pc_at_prediction_o_0,
    output logic [DATA_WIDTH-1:0]         pc_at_prediction_o_1,
    output logic [DATA_WIDTH-1:0]         pc_at_prediction_o_2,
    output logic                          branch_prediction_o_0,
    output logic                          branch_prediction_o_1,
    output logic                          branch_prediction_o_2,
    output logic [$clog2(ENTRIES):0]      global_history_o_0,
    output logic [$clog2(ENTRIES):0]      global_history_o_1,
    output logic [$clog2(ENTRIES):0]      global_history_o_2,
    output logic [2:0]                    ras_tos_checkpoint_o
`ifdef FETCH_DECODE_SKID_PERF_EN
    ,
    output logic [31:0]                   stall_cycles_o,
    output logic [31:0]                   bubble_cycles_o,
    output logic [31:0]                   bundles_o
`endif
);

    localparam int unsigned INDEX_WIDTH = $clog2(ENTRIES);
    localparam int unsigned GH_WIDTH    = INDEX_WIDTH + 1;
    localparam int unsigned LANES       = 3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instruction;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc_at_prediction;
        logic                  branch_prediction;
        logic [GH_WIDTH-1:0]   global_history;
    } lane_t;

    typedef struct packed {
        logic [LANES-1:0]      valid;
        lane_t [LANES-1:0]     lane;
        logic [2:0]            ras_tos;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    bundle_t          out_q, out_d;
    bundle_t          skid_q, skid_d;
    bundle_t          in_bundle;
    logic [LANES-1:0] ready_q, ready_d;
    logic             accept;
    logic             consume;

    // Gather the flat lane ports into one bundle.
    always_comb begin
        in_bundle                           = '0;
        in_bundle.valid                     = decode_valid_i;
        in_bundle.lane[0].instruction       = instruction_i_0;
        in_bundle.lane[1].instruction       = instruction_i_1;
        in_bundle.lane[2].instruction       = instruction_i_2;
        in_bundle.lane[0].pc                = pc_i_0;
        in_bundle.lane[1].pc                = pc_i_1;
        in_bundle.lane[2].pc                = pc_i_2;
        in_bundle.lane[0].imm               = imm_i_0;
        in_bundle.lane[1].imm               = imm_i_1;
        in_bundle.lane[2].imm               = imm_i_2;
        in_bundle.lane[0].pc_at_prediction  = pc_at_prediction_i_0;
        in_bundle.lane[1].pc_at_prediction  = pc_at_prediction_i_1;
        in_bundle.lane[2].pc_at_prediction  = pc_at_prediction_i_2;
        in_bundle.lane[0].branch_prediction = branch_prediction_i_0;
        in_bundle.lane[1].branch_prediction = branch_prediction_i_1;
        in_bundle.lane[2].branch_prediction = branch_prediction_i_2;
        in_bundle.lane[0].global_history    = global_history_i_0;
        in_bundle.lane[1].global_history    = global_history_i_1;
        in_bundle.lane[2].global_history    = global_history_i_2;
        in_bundle.ras_tos                   = ras_tos_checkpoint_i;
    end

    // Handshakes; flush vetoes both so nothing moves in a flush cycle.
    assign accept  = (|decode_valid_i) && ready_q[0] && !flush_i;
    assign consume = (|out_q.valid) && out_ready_i && !flush_i;

    // Next-state and next-payload.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        ready_d = ready_q;

        if (flush_i) begin
            state_d      = EMPTY;
            out_d.valid  = '0;
            skid_d.valid = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_d   = in_bundle;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        out_d = in_bundle;
                    end else if (accept) begin
                        skid_d  = in_bundle;
                        state_d = TWO;
                    end else if (consume) begin
                        out_d.valid = '0;
                        state_d     = EMPTY;
                    end
                end
                TWO: begin
                    // Ready is low here, so no accept can coincide.
                    if (consume) begin
                        out_d        = skid_q;
                        skid_d.valid = '0;
                        state_d      = ONE;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    out_d.valid  = '0;
                    skid_d.valid = '0;
                end
            endcase
        end

        // Ready is a registered copy of "next state is not full".
        ready_d = (state_d == TWO) ? 3'b000 : 3'b111;
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 3'b111;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign decode_ready_o        = ready_q;
    assign out_valid_o           = out_q.valid;
    assign instruction_o_0       = out_q.lane[0].instruction;
    assign instruction_o_1       = out_q.lane[1].instruction;
    assign instruction_o_2       = out_q.lane[2].instruction;
    assign pc_o_0                = out_q.lane[0].pc;
    assign pc_o_1                = out_q.lane[1].pc;
    assign pc_o_2                = out_q.lane[2].pc;
    assign imm_o_0               = out_q.lane[0].imm;
    assign imm_o_1               = out_q.lane[1].imm;
    assign imm_o_2               = out_q.lane[2].imm;
    assign pc_at_prediction_o_0  = out_q.lane[0].pc_at_prediction;
    assign pc_at_prediction_o_1  = out_q.lane[1].pc_at_prediction;
    assign pc_at_prediction_o_2  = out_q.lane[2].pc_at_prediction;
    assign branch_prediction_o_0 = out_q.lane[0].branch_prediction;
    assign branch_prediction_o_1 = out_q.lane[1].branch_prediction;
    assign branch_prediction_o_2 = out_q.lane[2].branch_prediction;
    assign global_history_o_0    = out_q.lane[0].global_history;
    assign global_history_o_1    = out_q.lane[1].global_history;
    assign global_history_o_2    = out_q.lane[2].global_history;
    assign ras_tos_checkpoint_o  = out_q.ras_tos;

`ifdef FETCH_DECODE_SKID_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] bubble_q;
    logic [31:0] bundles_q;

    // Saturating performance counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            bubble_q  <= '0;
            bundles_q <= '0;
        end else begin
            if (state_q == TWO && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (state_q == EMPTY && !flush_i && bubble_q != 32'hFFFF_FFFF) begin
                bubble_q <= bubble_q + 32'd1;
            end
            if (consume && bundles_q != 32'hFFFF_FFFF) begin
                bundles_q <= bundles_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o  = stall_q;
    assign bubble_cycles_o = bubble_q;
    assign bundles_o       = bundles_q;
`endif

endmodule

// File: tb/tb_fetch_decode_skid.sv
// Bench for fetch_decode_skid: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue model.
module tb_fetch_decode_skid;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [2:0]       dv;
    logic             out_ready;
    logic [2:0][31:0] instr_in, pc_in, imm_in, pap_in;
    logic [2:0]       bp_in;
    logic [2:0][5:0]  gh_in;
    logic [2:0]       ras_in;

    wire  [2:0]       ready_o;
    wire  [2:0]       ov;
    wire  [2:0][31:0] instr_out, pc_out, imm_out, pap_out;
    wire  [2:0]       bp_out;
    wire  [2:0][5:0]  gh_out;
    wire  [2:0]       ras_out;
`ifdef FETCH_DECODE_SKID_PERF_EN
    wire  [31:0]      stall_cnt, bubble_cnt, bundle_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_decode_skid #(.DATA_WIDTH(32), .ENTRIES(32)) dut (
        .clk(clk), .reset(reset), .flush_i(flush),
        .decode_valid_i(dv), .decode_ready_o(ready_o),
        .instruction_i_0(instr_in[0]), .instruction_i_1(instr_in[1]), .instruction_i_2(instr_in[2]),
        .pc_i_0(pc_in[0]), .pc_i_1(pc_in[1]), .pc_i_2(pc_in[2]),
        .imm_i_0(imm_in[0]), .imm_i_1(imm_in[1]), .imm_i_2(imm_in[2]),
        .pc_at_prediction_i_0(pap_in[0]), .pc_at_prediction_i_1(pap_in[1]), .pc_at_prediction_i_2(pap_in[2]),
        .branch_prediction_i_0(bp_in[0]), .branch_prediction_i_1(bp_in[1]), .branch_prediction_i_2(bp_in[2]),
        .global_history_i_0(gh_in[0]), .global_history_i_1(gh_in[1]), .global_history_i_2(gh_in[2]),
        .ras_tos_checkpoint_i(ras_in),
        .out_valid_o(ov), .out_ready_i(out_ready),
        .instruction_o_0(instr_out[0]), .instruction_o_1(instr_out[1]), .instruction_o_2(instr_out[2]),
        .pc_o_0(pc_out[0]), .pc_o_1(pc_out[1]), .pc_o_2(pc_out[2]),
        .imm_o_0(imm_out[0]), .imm_o_1(imm_out[1]), .imm_o_2(imm_out[2]),
        .pc_at_prediction_o_0(pap_out[0]), .pc_at_prediction_o_1(pap_out[1]), .pc_at_prediction_o_2(pap_out[2]),
        .branch_prediction_o_0(bp_out[0]), .branch_prediction_o_1(bp_out[1]), .branch_prediction_o_2(bp_out[2]),
        .global_history_o_0(gh_out[0]), .global_history_o_1(gh_out[1]), .global_history_o_2(gh_out[2]),
        .ras_tos_checkpoint_o(ras_out)
`ifdef FETCH_DECODE_SKID_PERF_EN
        ,
        .stall_cycles_o(stall_cnt), .bubble_cycles_o(bubble_cnt), .bundles_o(bundle_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order FIFO of at most two bundles.
    typedef struct packed {
        logic [2:0]       valid;
        logic [2:0][31:0] instr, pc, imm, pap;
        logic [2:0]       bp;
        logic [2:0][5:0]  gh;
        logic [2:0]       ras;
    } mb_t;

    mb_t q[$];
    bit  model_ok = 1'b0;

    always @(posedge clk) begin
        mb_t nb;
        bit  acc, cons;
        if (reset) begin
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc  = (dv != 3'b000) && (q.size() < 2) && !flush;
            cons = (q.size() > 0) && out_ready && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) begin
                    nb.valid = dv;    nb.instr = instr_in; nb.pc = pc_in;
                    nb.imm   = imm_in; nb.pap  = pap_in;   nb.bp = bp_in;
                    nb.gh    = gh_in;  nb.ras  = ras_in;
                    q.push_back(nb);
                end
            end
        end
    end

    // Compare process: checks DUT against the model mid-cycle.
    always @(negedge clk) begin
        logic [2:0] ev;
        if (model_ok) begin
            ev = (q.size() > 0) ? q[0].valid : 3'b000;
            check("out_valid", 32'(ov), 32'(ev));
            check("decode_ready", 32'(ready_o), (q.size() < 2) ? 32'd7 : 32'd0);
            if (q.size() > 0) begin
                check("ras_tos", 32'(ras_out), 32'(q[0].ras));
                for (int l = 0; l < 3; l++) begin
                    if (q[0].valid[l]) begin
                        check($sformatf("instr%0d", l), instr_out[l], q[0].instr[l]);
                        check($sformatf("pc%0d", l), pc_out[l], q[0].pc[l]);
                        check($sformatf("imm%0d", l), imm_out[l], q[0].imm[l]);
                        check($sformatf("pap%0d", l), pap_out[l], q[0].pap[l]);
                        check($sformatf("bp%0d", l), 32'(bp_out[l]), 32'(q[0].bp[l]));
                        check($sformatf("gh%0d", l), 32'(gh_out[l]), 32'(q[0].gh[l]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_payload();
        for (int l = 0; l < 3; l++) begin
            instr_in[l] = $urandom;
            imm_in[l]   = $urandom;
            pap_in[l]   = $urandom;
            pc_in[l]    = $urandom;
            bp_in[l]    = 1'($urandom_range(1));
            gh_in[l]    = 6'($urandom_range(63));
        end
        ras_in = 3'($urandom_range(7));
    endtask

    task automatic set_bundle(input logic [2:0] v, input logic [31:0] pc_base);
        randomize_payload();
        dv = v;
        for (int l = 0; l < 3; l++) pc_in[l] = pc_base + 32'(4 * l);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; dv = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n_out;
        logic [2:0] vsel;
        reset = 1'b1; flush = 1'b0; dv = 3'b000; out_ready = 1'b0;
        randomize_payload();
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(ov), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd7);
        check("rst_pc0", pc_out[0], 32'd0);
        check("rst_instr2", instr_out[2], 32'd0);
        check("rst_ras", 32'(ras_out), 32'd0);

        // Two-lane bundle passes with one cycle latency.
        out_ready = 1'b1;
        set_bundle(3'b011, 32'h100);
        tick();
        check("lat_valid", 32'(ov), 32'd3);
        check("lat_pc0", pc_out[0], 32'h100);
        check("lat_pc1", pc_out[1], 32'h104);
        dv = 3'b000;
        tick();
        check("lat_drain", 32'(ov), 32'd0);

        // Stall fills skid; release drains A then B.
        out_ready = 1'b0;
        set_bundle(3'b001, 32'h200);
        tick();
        set_bundle(3'b001, 32'h20C);
        tick();
        check("full_ready", 32'(ready_o), 32'd0);
        check("full_pcA", pc_out[0], 32'h200);
        dv = 3'b000;
        repeat (2) tick();
        check("hold_pcA", pc_out[0], 32'h200);
        out_ready = 1'b1;
        tick();
        check("drain_pcB", pc_out[0], 32'h20C);
        check("drain_ready", 32'(ready_o), 32'd7);
        tick();
        check("drain_empty", 32'(ov), 32'd0);

        // Flush while full with a valid input bundle.
        out_ready = 1'b0;
        set_bundle(3'b111, 32'h300);
        tick();
        set_bundle(3'b111, 32'h30C);
        tick();
        flush = 1'b1;
        set_bundle(3'b111, 32'h400);
        tick();
        flush = 1'b0; dv = 3'b000; out_ready = 1'b1;
        check("flush_valid", 32'(ov), 32'd0);
        check("flush_ready", 32'(ready_o), 32'd7);
        tick();
        check("flush_noinput", 32'(ov), 32'd0);

        // Streaming: one bundle per cycle, ready never drops.
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            set_bundle(3'b111, 32'h1000 + 32'(16 * i));
            tick();
            check("stream_pc0", pc_out[0], 32'h1000 + 32'(16 * i));
            check("stream_ready", 32'(ready_o), 32'd7);
            if (ov == 3'b111) n_out++;
        end
        check("stream_count", 32'(n_out), 32'd10);
        dv = 3'b000;
        tick();

`ifdef FETCH_DECODE_SKID_PERF_EN
        do_reset();
        out_ready = 1'b0;
        set_bundle(3'b001, 32'h500);
        tick();
        set_bundle(3'b001, 32'h504);
        tick();
        dv = 3'b000;
        repeat (5) tick();
        check("perf_stall", stall_cnt, 32'd5);
        out_ready = 1'b1;
        repeat (2) tick();
        check("perf_bundles", bundle_cnt, 32'd2);
`endif

        // Reset dominates flush while full.
        out_ready = 1'b0;
        set_bundle(3'b111, 32'h600);
        tick();
        set_bundle(3'b111, 32'h60C);
        tick();
        reset = 1'b1; flush = 1'b1; dv = 3'b000;
        tick();
        reset = 1'b0; flush = 1'b0;
        check("rst2_valid", 32'(ov), 32'd0);
        check("rst2_ready", 32'(ready_o), 32'd7);
        check("rst2_pc0", pc_out[0], 32'd0);
        check("rst2_instr1", instr_out[1], 32'd0);
        check("rst2_ras", 32'(ras_out), 32'd0);

        // Randomized traffic, checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            randomize_payload();
            vsel      = 3'($urandom_range(3));
            dv        = (vsel == 0) ? 3'b000 : (vsel == 1) ? 3'b001 : (vsel == 2) ? 3'b011 : 3'b111;
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(19) == 0);
            reset     = ($urandom_range(499) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; dv = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_skid.md
FETCH_DECODE_SKID -- requirements
Module: fetch_decode_skid

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of instruction/PC/immediate fields.
REQ-002 Parameter ENTRIES, default 32, predictor entries; INDEX_WIDTH = $clog2(ENTRIES), global history width INDEX_WIDTH+1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flush_i  in  1  eager flush (OR of misprediction_i_0/1/2).
REQ-006 decode_valid_i  in  3  per-lane valid from instruction buffer; contiguous from lane 0 (000/001/011/111).
REQ-007 decode_ready_o  out  3  ready to instruction buffer; all bits equal.
REQ-008 instruction_i_0/1/2, pc_i_0/1/2, imm_i_0/1/2, pc_at_prediction_i_0/1/2  in  DATA_WIDTH each  lane payload.
REQ-009 branch_prediction_i_0/1/2  in  1 each; global_history_i_0/1/2  in  INDEX_WIDTH+1 each; ras_tos_checkpoint_i  in  3 (per bundle).
REQ-010 out_valid_o  out  3  per-lane valid to decode.
REQ-011 out_ready_i  in  1  decode consumes the whole presented bundle.
REQ-012 instruction_o_*, pc_o_*, imm_o_*, pc_at_prediction_o_*, branch_prediction_o_*, global_history_o_*, ras_tos_checkpoint_o  out  widths as inputs  registered payload.

Function
REQ-013 Block SHALL be a bundle-granular two-entry skid buffer: output register (OUT) plus skid register (SKID).
REQ-014 States SHALL be EMPTY (neither valid), ONE (OUT valid), TWO (OUT and SKID valid); SKID valid implies OUT valid.
REQ-015 decode_ready_o SHALL be 3'b111 in EMPTY/ONE and 3'b000 in TWO; it SHALL depend only on registered state.
REQ-016 Accept SHALL occur when decode_valid_i != 0 and decode_ready_o == 111 and flush_i == 0; all valid lanes captured together.
REQ-017 Consume SHALL occur when out_valid_o != 0 and out_ready_i == 1 and flush_i == 0.
REQ-018 EMPTY: accept -> ONE, bundle in OUT; latency input-to-output exactly 1 cycle.
REQ-019 ONE: accept+consume -> ONE (new bundle to OUT); accept only -> TWO (new bundle to SKID); consume only -> EMPTY.
REQ-020 TWO: consume -> ONE, SKID moves to OUT, SKID cleared; no consume -> hold.
REQ-021 Order SHALL be preserved; no bundle duplicated or dropped absent flush.
REQ-022 out_valid_o SHALL equal stored lane mask of OUT; 000 in EMPTY; payload of invalid lanes don't-care but SHALL be held stable while OUT held.
REQ-023 flush_i SHALL clear OUT and SKID next cycle (-> EMPTY), discard any same-cycle input bundle, and suppress consume; flush dominates accept/consume.
REQ-024 decode_valid_i == 000 SHALL never change state except via consume/flush.

Reset
REQ-025 On reset: state EMPTY, out_valid_o 000, decode_ready_o 111 next cycle, all payload registers 0, ras_tos_checkpoint_o 0.
REQ-026 reset SHALL dominate flush_i, accept and consume; reset mid-TWO discards both bundles.

Configuration
REQ-027 Macro FETCH_DECODE_SKID_PERF_EN: when defined, add outputs stall_cycles_o (32) counting cycles in TWO, bubble_cycles_o (32) counting cycles in EMPTY without flush, bundles_o (32) counting consumes; all saturate at 0xFFFFFFFF, reset to 0, not cleared by flush.
REQ-028 Without FETCH_DECODE_SKID_PERF_EN those ports and counters SHALL not exist; functional behaviour identical.

Verification
REQ-029 After reset, valid=011, pc_0=0x100, pc_1=0x104, out_ready_i=1 -> next cycle out_valid_o=011, pc_o_0=0x100, pc_o_1=0x104.
REQ-030 out_ready_i=0, send bundles A(pc 0x200) then B(pc 0x20C) -> state TWO, decode_ready_o=000; raise out_ready_i -> A then B in consecutive cycles, ready 111 after A leaves.
REQ-031 State TWO, flush_i=1 with valid=111 input -> next cycle out_valid_o=000, ready=111; input bundle never appears.
REQ-032 Continuous valid=111, out_ready_i=1 for 10 cycles -> 10 bundles out, one per cycle, in order, ready never drops.
REQ-033 reset asserted in TWO with flush_i=1 -> next cycle EMPTY, all outputs zero.
REQ-034 With FETCH_DECODE_SKID_PERF_EN: hold out_ready_i=0 for 5 cycles in TWO -> stall_cycles_o=5; then 2 consumes -> bundles_o incremented by 2.
